// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the writeback arbiter and its neighbours.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle: per-requester valid/addr/data plus the returned one-hot grant and stall.
interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*REG_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]            req_grant;
    logic                          hold;

    modport master (output req_valid, req_addr, req_data, hold, input req_grant);
    modport slave  (input req_valid, req_addr, req_data, hold, output req_grant);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating priority pointer.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            // Grants are suppressed while in reset so nothing leaks out before the pointer is valid
            if (!found && req[idx] && !hold && !rst) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the reg3232 write port among NUM_REQ writeback units; registered write, commit counter.
// Optional write-to-read forwarding on the read ports when REGARB_BYPASS_EN is defined.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wr_arbiter_if.slave   req_if,
    output logic                  w_en,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [REG_DATA_W-1:0] w_data,
    input  logic [REG_ADDR_W-1:0] rd_addr0,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_DATA_W-1:0] rf_rdata0,
    input  logic [REG_DATA_W-1:0] rf_rdata1,
    output logic [REG_DATA_W-1:0] rd_data0,
    output logic [REG_DATA_W-1:0] rd_data1,
    output logic [CNT_W-1:0]      wr_count
);
    logic [NUM_REQ-1:0]    grant;
    logic [REG_ADDR_W-1:0] addr_masked [NUM_REQ];
    logic [REG_DATA_W-1:0] data_masked [NUM_REQ];
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [REG_DATA_W-1:0] sel_data;

    logic                  w_en_q, w_en_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [REG_DATA_W-1:0] w_data_q, w_data_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_if.req_valid),
        .hold  (req_if.hold),
        .grant (grant)
    );

    assign req_if.req_grant = grant;

    // Grant is one-hot, so an AND-OR mux selects the winner's payload
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign addr_masked[gi] = grant[gi] ? req_if.req_addr[gi*REG_ADDR_W +: REG_ADDR_W] : '0;
        assign data_masked[gi] = grant[gi] ? req_if.req_data[gi*REG_DATA_W +: REG_DATA_W] : '0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr = sel_addr | addr_masked[i];
            sel_data = sel_data | data_masked[i];
        end
    end

    always_comb begin
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        wr_count_d = wr_count_q;
        if (|grant) begin
            // r0 writes are accepted to free the requester but never reach the file
            w_en_d   = (sel_addr != REG_ZERO);
            w_addr_d = sel_addr;
            w_data_d = sel_data;
        end
        if (w_en_q && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            wr_count_q <= '0;
        end else begin
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign w_en     = w_en_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign wr_count = wr_count_q;

`ifdef REGARB_BYPASS_EN
    assign rd_data0 = (w_en_q && (rd_addr0 == w_addr_q) && (rd_addr0 != REG_ZERO)) ? w_data_q : rf_rdata0;
    assign rd_data1 = (w_en_q && (rd_addr1 == w_addr_q) && (rd_addr1 != REG_ZERO)) ? w_data_q : rf_rdata1;
`else
    logic rd_addr_unused;
    assign rd_addr_unused = ^{rd_addr0, rd_addr1};
    assign rd_data0 = rf_rdata0;
    assign rd_data1 = rf_rdata1;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wr_arbiter;
    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  rd_addr0 = '0, rd_addr1 = '0;
    logic [31:0] rf_rdata0 = '0, rf_rdata1 = '0;
    logic [31:0] rd_data0, rd_data1;
    logic [15:0] wr_count;

    regfile_wr_arbiter_if #(.NUM_REQ(NR)) bus ();

    regfile_wr_arbiter #(.NUM_REQ(NR), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_if(bus),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Requester state: a pending write stays offered until it is granted
    bit          pend [NR];
    logic [4:0]  paddr [NR];
    logic [31:0] pdata [NR];
    bit          hold_v = 1'b0;

    // Reference model of the architecturally visible state
    int          ptr_m = 0;
    bit          w_en_m = 1'b0;
    logic [4:0]  w_addr_m = '0;
    logic [31:0] w_data_m = '0;
    int          cnt_m = 0;
    int          last_w = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] rf);
`ifdef REGARB_BYPASS_EN
        if (w_en_m && a == w_addr_m && a != 5'd0) return w_data_m;
`endif
        return rf;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = pend[i];
            bus.req_addr[i*5 +: 5]    = paddr[i];
            bus.req_data[i*32 +: 32]  = pdata[i];
        end
        bus.hold = hold_v;
    endtask

    task automatic model_reset();
        ptr_m = 0; w_en_m = 0; w_addr_m = '0; w_data_m = '0; cnt_m = 0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check registers
    task automatic step();
        int w;
        logic [2:0] eg;
        bit n_we; logic [4:0] n_wa; logic [31:0] n_wd; int n_ptr; int n_cnt;
        drive();
        #2;
        w = -1;
        if (!hold_v)
            for (int k = 0; k < NR; k++)
                if (w < 0 && pend[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
        eg = (w >= 0) ? 3'(1 << w) : 3'b000;
        check("grant", {29'd0, bus.req_grant}, {29'd0, eg});
        check("rd_data0", rd_data0, exp_rd(rd_addr0, rf_rdata0));
        check("rd_data1", rd_data1, exp_rd(rd_addr1, rf_rdata1));
        n_we = 0; n_wa = w_addr_m; n_wd = w_data_m; n_ptr = ptr_m;
        if (w >= 0) begin
            n_we = (paddr[w] != 5'd0); n_wa = paddr[w]; n_wd = pdata[w];
            n_ptr = (w + 1) % NR;
            pend[w] = 0;
        end
        n_cnt = (w_en_m && cnt_m != 65535) ? cnt_m + 1 : cnt_m;
        @(posedge clk); #1;
        w_en_m = n_we; w_addr_m = n_wa; w_data_m = n_wd; ptr_m = n_ptr; cnt_m = n_cnt;
        last_w = w;
        check("w_en", {31'd0, w_en}, {31'd0, w_en_m});
        check("w_addr", {27'd0, w_addr}, {27'd0, w_addr_m});
        check("w_data", w_data, w_data_m);
        check("wr_count", {16'd0, wr_count}, 32'(cnt_m));
        $display("cycle t=%0t grant=%b w_en=%b w_addr=%0d w_data=%h wr_count=%0d",
                 $time, bus.req_grant, w_en, w_addr, w_data, wr_count);
    endtask

    initial begin
        int cnt_before;
        for (int i = 0; i < NR; i++) begin pend[i] = 1; paddr[i] = 5'(10 + i); pdata[i] = 32'hA0 + i; end
        drive();
        // 1. Reset with valids present: grants forced low, registers cleared
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", {29'd0, bus.req_grant}, 32'd0);
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        for (int i = 0; i < NR; i++) pend[i] = 0;
        drive();
        rst = 0;
        model_reset();
        repeat (3) step();

        // 3. Round-robin with all valid continuously
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) begin pend[i] = 1; paddr[i] = 5'(10 + i); pdata[i] = 32'h100 * (k + 1) + i; end
            step();
            check("rr_order", 32'(last_w), 32'(k % NR));
            check("rr_w_addr", {27'd0, w_addr}, 32'(10 + (k % NR)));
        end
        for (int i = 0; i < NR; i++) pend[i] = 0;
        step(); step();

        // 2. Single request from requester 1
        cnt_before = cnt_m;
        pend[1] = 1; paddr[1] = 5'd8; pdata[1] = 32'h7;
        step();
        check("single_w_en", {31'd0, w_en}, 32'd1);
        check("single_w_addr", {27'd0, w_addr}, 32'd8);
        check("single_w_data", w_data, 32'h7);
        step();
        check("single_count", {16'd0, wr_count}, 32'(cnt_before + 1));

        // 4. Write to r0: granted, dropped
        cnt_before = cnt_m;
        pend[0] = 1; paddr[0] = 5'd0; pdata[0] = 32'hFFFF_FFFF;
        step();
        check("r0_granted", 32'(last_w), 32'd0);
        check("r0_w_en", {31'd0, w_en}, 32'd0);
        step();
        check("r0_count", {16'd0, wr_count}, 32'(cnt_before));

        // 5a. Hold with all valid: no grants for 3 cycles
        for (int i = 0; i < NR; i++) begin pend[i] = 1; paddr[i] = 5'(20 + i); pdata[i] = 32'hB00 + i; end
        hold_v = 1;
        repeat (3) begin
            step();
            check("hold_no_grant", 32'(last_w), 32'hFFFF_FFFF);
        end
        hold_v = 0;
        repeat (4) step();

        // 6. Bypass
        pend[0] = 1; paddr[0] = 5'd4; pdata[0] = 32'h7;
        step();
        rd_addr0 = 5'd4; rf_rdata0 = 32'h0; rd_addr1 = 5'd3; rf_rdata1 = 32'h1234_5678;
        #1;
`ifdef REGARB_BYPASS_EN
        check("bypass_rd0", rd_data0, 32'h7);
`else
        check("bypass_rd0", rd_data0, 32'h0);
`endif
        check("bypass_rd1", rd_data1, 32'h1234_5678);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1; paddr[i] = 5'($urandom_range(0, 31)); pdata[i] = $urandom;
                end
            hold_v    = ($urandom_range(0, 7) == 0);
            rd_addr0  = $urandom_range(0, 1) ? w_addr_m : 5'($urandom_range(0, 31));
            rd_addr1  = $urandom_range(0, 1) ? w_addr_m : 5'($urandom_range(0, 31));
            rf_rdata0 = $urandom;
            rf_rdata1 = $urandom;
            step();
        end
        hold_v = 0;

        // 5b. Asynchronous reset while a write is pending on the port
        for (int i = 0; i < NR; i++) pend[i] = 0;
        pend[2] = 1; paddr[2] = 5'd9; pdata[2] = 32'hDEAD_BEEF;
        step();
        check("pre_rst_w_en", {31'd0, w_en}, 32'd1);
        for (int i = 0; i < NR; i++) begin pend[i] = 1; paddr[i] = 5'(1 + i); pdata[i] = 32'hC0 + i; end
        drive();
        #1;
        rst = 1;
        #1;
        check("arst_w_en", {31'd0, w_en}, 32'd0);
        check("arst_wr_count", {16'd0, wr_count}, 32'd0);
        check("arst_grant", {29'd0, bus.req_grant}, 32'd0);
        check("arst_w_addr", {27'd0, w_addr}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        check("arst_hold_w_en", {31'd0, w_en}, 32'd0);
        rst = 0;
        // After reset the pointer restarts at requester 0
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NR; i++) if (!pend[i]) pend[i] = 1;
            step();
            check("post_rst_order", 32'(last_w), 32'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
